// File: rtl/pc_unit.sv
// pc_unit: fetch-stage program counter with BOOT/RUN/HALT control and
// exc > jump > ret > branch > halt > stall redirect priority. Targets that
// are not STEP-aligned trap to EXC_VEC.
// Optional return-address stack, built when PC_UNIT_RAS_EN is defined.
module pc_unit #(
  parameter int unsigned       WIDTH     = 32,
  parameter int unsigned       STEP      = 4,
  parameter logic [WIDTH-1:0]  RESET_VEC = '0,
  parameter logic [WIDTH-1:0]  EXC_VEC   = WIDTH'(32'h80),
  parameter int unsigned       RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             exc,
  input  logic             halt,
  input  logic             call,
  input  logic             ret,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_seq,
  output logic             fetch_valid,
  output logic             flush,
  output logic             misalign,
  output logic             ras_full,
  output logic             ras_err
);

  localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(STEP - 1);

  typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_HALT} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] pc_nxt;
  logic             fetch_valid_nxt;
  logic             flush_nxt;
  logic             misalign_nxt;
  logic             push;
  logic             pop;
  logic             ras_err_nxt;
  logic             ras_empty;
  logic [WIDTH-1:0] ras_top;

  // Sequential fetch address, wraps modulo 2^WIDTH
  assign pc_seq = pc + WIDTH'(STEP);

`ifdef PC_UNIT_RAS_EN
  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] ras_ptr;
  logic [CNT_W-1:0] ras_cnt;

  assign ras_empty = (ras_cnt == '0);
  assign ras_full  = (ras_cnt == CNT_W'(RAS_DEPTH));
  assign ras_top   = ras_mem[ras_ptr - PTR_W'(1)];

  // Stack pointer/occupancy; a push when full overwrites the oldest entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ras_ptr <= '0;
      ras_cnt <= '0;
      ras_err <= 1'b0;
    end else begin
      ras_err <= ras_err_nxt;
      if (push) begin
        ras_ptr <= ras_ptr + PTR_W'(1);
        if (!ras_full) ras_cnt <= ras_cnt + CNT_W'(1);
      end else if (pop) begin
        ras_ptr <= ras_ptr - PTR_W'(1);
        ras_cnt <= ras_cnt - CNT_W'(1);
      end
    end
  end

  // Return-address storage, no reset needed
  always_ff @(posedge clk) begin
    if (push) ras_mem[ras_ptr] <= pc_seq;
  end
`else
  logic unused_ras;
  assign unused_ras = call ^ ret ^ (RAS_DEPTH == 0) ^ push ^ pop ^ ras_err_nxt;
  assign ras_empty  = 1'b1;
  assign ras_top    = '0;
  assign ras_full   = 1'b0;
  assign ras_err    = 1'b0;
`endif

  // Next-state, next-PC and redirect pulse selection
  always_comb begin
    state_nxt       = state;
    pc_nxt          = pc;
    fetch_valid_nxt = fetch_valid;
    flush_nxt       = 1'b0;
    misalign_nxt    = 1'b0;
    ras_err_nxt     = 1'b0;
    push            = 1'b0;
    pop             = 1'b0;
    case (state)
      ST_BOOT: begin
        state_nxt       = ST_RUN;
        fetch_valid_nxt = 1'b1;
      end
      ST_RUN: begin
        if (exc) begin
          pc_nxt    = EXC_VEC;
          flush_nxt = 1'b1;
        end else if (jump) begin
          flush_nxt = 1'b1;
          if ((jump_target & ALIGN_MASK) != '0) begin
            pc_nxt       = EXC_VEC;
            misalign_nxt = 1'b1;
          end else begin
            pc_nxt = jump_target;
`ifdef PC_UNIT_RAS_EN
            push   = call;
`endif
          end
`ifdef PC_UNIT_RAS_EN
        end else if (ret) begin
          flush_nxt = 1'b1;
          if (ras_empty) begin
            pc_nxt      = EXC_VEC;
            ras_err_nxt = 1'b1;
          end else begin
            pop = 1'b1;
            if ((ras_top & ALIGN_MASK) != '0) begin
              pc_nxt       = EXC_VEC;
              misalign_nxt = 1'b1;
            end else begin
              pc_nxt = ras_top;
            end
          end
`endif
        end else if (branch_taken) begin
          flush_nxt = 1'b1;
          if ((branch_target & ALIGN_MASK) != '0) begin
            pc_nxt       = EXC_VEC;
            misalign_nxt = 1'b1;
          end else begin
            pc_nxt = branch_target;
          end
        end else if (halt) begin
          state_nxt       = ST_HALT;
          fetch_valid_nxt = 1'b0;
        end else if (!stall) begin
          pc_nxt = pc_seq;
        end
      end
      ST_HALT: begin
        if (exc) begin
          state_nxt       = ST_RUN;
          pc_nxt          = EXC_VEC;
          fetch_valid_nxt = 1'b1;
          flush_nxt       = 1'b1;
        end
      end
      default: begin
        state_nxt       = ST_BOOT;
        pc_nxt          = RESET_VEC;
        fetch_valid_nxt = 1'b0;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_BOOT;
      pc          <= RESET_VEC;
      fetch_valid <= 1'b0;
      flush       <= 1'b0;
      misalign    <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      fetch_valid <= fetch_valid_nxt;
      flush       <= flush_nxt;
      misalign    <= misalign_nxt;
    end
  end

endmodule
